// File: rtl/umul_stream_if.sv
// Shared clock/reset bundle for the fixed-point datapath blocks.
// WIDTH is the operand width used by every block on this bundle.
interface fixedp #(
    parameter int WIDTH = 8
);
    logic clk;
    logic reset;

    modport dut (
        input clk,
        input reset
    );
endinterface

// File: rtl/umul_stream.sv
// Pipelined WIDTH x WIDTH -> 2*WIDTH multiplier, signed or unsigned per beat,
// with a sideband tag and a single global advance for valid/ready flow control.
module umul_stream #(
    parameter int WIDTH      = 8,
    parameter int IN_STAGES  = 2,
    parameter int OUT_STAGES = 1,
    parameter int TAG_W      = 4
) (
    fixedp.dut                 g,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    input  logic [TAG_W-1:0]   tag_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] f,
    output logic [TAG_W-1:0]   tag_out
);

    localparam int PW = 2 * WIDTH;

    logic             adv;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    logic             m_s;
    logic             m_v;
    logic [TAG_W-1:0] m_t;

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    if (IN_STAGES == 0) begin : g_no_in
        assign m_a = a;
        assign m_b = b;
        assign m_s = sgn;
        assign m_t = tag_in;
        assign m_v = in_valid;
    end else begin : g_in
        logic [WIDTH-1:0] a_r [IN_STAGES];
        logic [WIDTH-1:0] b_r [IN_STAGES];
        logic             s_r [IN_STAGES];
        logic [TAG_W-1:0] t_r [IN_STAGES];
        logic             v_r [IN_STAGES];

        always_ff @(posedge g.clk) begin
            if (g.reset) begin
                for (int i = 0; i < IN_STAGES; i++) begin
                    v_r[i] <= 1'b0;
                end
            end else if (adv) begin
                v_r[0] <= in_valid;
                for (int i = 1; i < IN_STAGES; i++) begin
                    v_r[i] <= v_r[i-1];
                end
            end
        end

        // Operand registers carry no reset so they can be retimed into a DSP.
        always_ff @(posedge g.clk) begin
            if (adv) begin
                a_r[0] <= a;
                b_r[0] <= b;
                s_r[0] <= sgn;
                t_r[0] <= tag_in;
                for (int i = 1; i < IN_STAGES; i++) begin
                    a_r[i] <= a_r[i-1];
                    b_r[i] <= b_r[i-1];
                    s_r[i] <= s_r[i-1];
                    t_r[i] <= t_r[i-1];
                end
            end
        end

        assign m_a = a_r[IN_STAGES-1];
        assign m_b = b_r[IN_STAGES-1];
        assign m_s = s_r[IN_STAGES-1];
        assign m_t = t_r[IN_STAGES-1];
        assign m_v = v_r[IN_STAGES-1];
    end

    // Extending to 2*WIDTH makes the truncated product exact in both modes.
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    logic [PW-1:0] prod;

    always_comb begin
        ax   = {{WIDTH{m_s & m_a[WIDTH-1]}}, m_a};
        bx   = {{WIDTH{m_s & m_b[WIDTH-1]}}, m_b};
        prod = ax * bx;
    end

    logic [PW-1:0]    p_o [OUT_STAGES+1];
    logic [TAG_W-1:0] t_o [OUT_STAGES+1];
    logic             v_o [OUT_STAGES+1];

    always_ff @(posedge g.clk) begin
        if (g.reset) begin
            for (int i = 0; i <= OUT_STAGES; i++) begin
                p_o[i] <= '0;
                t_o[i] <= '0;
                v_o[i] <= 1'b0;
            end
        end else if (adv) begin
            p_o[0] <= prod;
            t_o[0] <= m_t;
            v_o[0] <= m_v;
            for (int i = 1; i <= OUT_STAGES; i++) begin
                p_o[i] <= p_o[i-1];
                t_o[i] <= t_o[i-1];
                v_o[i] <= v_o[i-1];
            end
        end
    end

    assign out_valid = v_o[OUT_STAGES];
    assign f         = p_o[OUT_STAGES];
    assign tag_out   = t_o[OUT_STAGES];

    a_stall_hold: assert property (
        @(posedge g.clk) disable iff (g.reset)
        (out_valid && !out_ready) |=>
        (out_valid && $stable(f) && $stable(tag_out))
    );

    a_reset_empty: assert property (
        @(posedge g.clk) g.reset |=> !out_valid
    );

endmodule

// File: tb/tb_umul_stream.sv
// Bench for umul_stream: default pipe plus LAT=1 and LAT=9 variants fed
// the same accepted beats, each checked against its own scoreboard queue.
module tb_umul_stream;

    localparam int W  = 8;
    localparam int TW = 4;

    fixedp #(.WIDTH(W)) g ();

    logic          in_valid;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sgn;
    logic [TW-1:0] tag_in;
    logic          out_ready;
    logic          iv_x;

    logic            in_ready0, in_ready1, in_ready2;
    logic            ov0, ov1, ov2;
    logic [2*W-1:0]  f0, f1, f2;
    logic [TW-1:0]   to0, to1, to2;

    assign iv_x = in_valid & in_ready0;

    umul_stream #(.WIDTH(W), .IN_STAGES(2), .OUT_STAGES(1), .TAG_W(TW)) d0 (
        .g(g), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .sgn(sgn), .tag_in(tag_in),
        .out_valid(ov0), .out_ready(out_ready), .f(f0), .tag_out(to0)
    );

    umul_stream #(.WIDTH(W), .IN_STAGES(0), .OUT_STAGES(0), .TAG_W(TW)) d1 (
        .g(g), .in_valid(iv_x), .in_ready(in_ready1),
        .a(a), .b(b), .sgn(sgn), .tag_in(tag_in),
        .out_valid(ov1), .out_ready(1'b1), .f(f1), .tag_out(to1)
    );

    umul_stream #(.WIDTH(W), .IN_STAGES(4), .OUT_STAGES(4), .TAG_W(TW)) d2 (
        .g(g), .in_valid(iv_x), .in_ready(in_ready2),
        .a(a), .b(b), .sgn(sgn), .tag_in(tag_in),
        .out_valid(ov2), .out_ready(1'b1), .f(f2), .tag_out(to2)
    );

    initial g.clk = 1'b0;
    always #5 g.clk = ~g.clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit lat_on = 1'b1;
    bit rnd_rdy = 1'b0;

    always @(posedge g.clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] f;
        logic [TW-1:0]  tag;
        int             t;
    } sb_t;

    sb_t q[3][$];

    typedef struct {
        logic [W-1:0]   va;
        logic [W-1:0]   vb;
        logic           vs;
        logic [TW-1:0]  vt;
        logic [2*W-1:0] ef;
    } vec_t;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x,
                                               input logic [W-1:0] y,
                                               input logic s);
        int xi, yi, p;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        p  = xi * yi;
        return p[2*W-1:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", nm);
    endtask

    task automatic mon(input int k, input int lat, input bit chk_l,
                       input logic acc, input logic emit,
                       input logic [2*W-1:0] fv, input logic [TW-1:0] tv);
        sb_t e;
        if (g.reset) begin
            q[k].delete();
        end else begin
            if (acc) begin
                e.f   = ref_mul(a, b, sgn);
                e.tag = tag_in;
                e.t   = cyc;
                q[k].push_back(e);
            end
            if (emit) begin
                if (q[k].size() == 0) begin
                    fail_now($sformatf("dut%0d emit with empty scoreboard f=0x%0h", k, fv));
                end else begin
                    e = q[k].pop_front();
                    chk($sformatf("dut%0d f", k), 32'(fv), 32'(e.f));
                    chk($sformatf("dut%0d tag", k), 32'(tv), 32'(e.tag));
                    if (chk_l) chk($sformatf("dut%0d latency", k), cyc - e.t, lat);
                end
            end
        end
    endtask

    always @(negedge g.clk) begin
        mon(0, 4, lat_on, in_valid & in_ready0, ov0 & out_ready, f0, to0);
        mon(1, 1, 1'b1, iv_x & in_ready1, ov1, f1, to1);
        mon(2, 9, 1'b1, iv_x & in_ready2, ov2, f2, to2);
    end

    always @(posedge g.clk) begin
        if (rnd_rdy) begin
            #1 out_ready = 1'($urandom_range(1));
        end
    end

    task automatic sync();
        @(posedge g.clk);
        #1;
    endtask

    // Call between posedge+1 and the following negedge.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic s, input logic [TW-1:0] t);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        sgn = s;
        tag_in = t;
        for (int i = 0; i < 300; i++) begin
            @(negedge g.clk);
            if (in_ready0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("send timeout waiting for in_ready");
        sync();
        in_valid = 1'b0;
    endtask

    task automatic wait_ov(input int lim, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge g.clk);
            if (ov0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now($sformatf("%s timeout waiting for out_valid", nm));
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 600; i++) begin
            @(negedge g.clk);
            if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) break;
        end
        chk({nm, " q0 empty"}, q[0].size(), 0);
        chk({nm, " q1 empty"}, q[1].size(), 0);
        chk({nm, " q2 empty"}, q[2].size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    vec_t vt[7];
    logic [2*W-1:0] sf;
    logic [TW-1:0] st;
    int run;

    initial begin
        vt[0] = '{8'hFF, 8'hFF, 1'b0, 4'd3, 16'hFE01};
        vt[1] = '{8'hFF, 8'hFF, 1'b1, 4'd5, 16'h0001};
        vt[2] = '{8'h80, 8'h80, 1'b1, 4'd6, 16'h4000};
        vt[3] = '{8'h80, 8'h7F, 1'b1, 4'd7, 16'hC080};
        vt[4] = '{8'h00, 8'h80, 1'b1, 4'd8, 16'h0000};
        vt[5] = '{8'h80, 8'h80, 1'b0, 4'd9, 16'h4000};
        vt[6] = '{8'h7F, 8'hFF, 1'b1, 4'd10, 16'hFF81};

        g.reset = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sgn = 1'b0;
        tag_in = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge g.clk);
        #1 g.reset = 1'b0;
        @(negedge g.clk);
        chk("reset in_ready", in_ready0, 1);
        chk("reset out_valid", ov0, 0);
        chk("reset f", f0, 0);
        chk("reset tag_out", to0, 0);

        foreach (vt[i]) begin
            sync();
            send(vt[i].va, vt[i].vb, vt[i].vs, vt[i].vt);
            wait_ov(20, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d f", i), 32'(f0), 32'(vt[i].ef));
            chk($sformatf("vec%0d tag", i), 32'(to0), 32'(vt[i].vt));
        end

        sync();
        fork
            begin
                for (int i = 0; i < 16; i++) send(8'(i), 8'(2 * i), 1'b0, 4'(i));
            end
            begin
                run = 0;
                wait_ov(20, "b2b");
                for (int j = 0; j < 40; j++) begin
                    if (!ov0) break;
                    chk($sformatf("b2b f%0d", j), 32'(f0), 2 * j * j);
                    run++;
                    @(negedge g.clk);
                end
                chk("b2b consecutive out_valid", run, 16);
            end
        join
        drain("b2b");

        lat_on = 1'b0;
        sync();
        fork
            begin
                for (int i = 0; i < 12; i++) send(8'(i + 20), 8'hFD, 1'(i), 4'(i));
            end
            begin
                repeat (7) @(posedge g.clk);
                #1 out_ready = 1'b0;
                @(negedge g.clk);
                sf = f0;
                st = to0;
                chk("stall out_valid", ov0, 1);
                chk("stall in_ready", in_ready0, 0);
                for (int k = 0; k < 4; k++) begin
                    @(negedge g.clk);
                    chk($sformatf("stall%0d f stable", k), 32'(f0), 32'(sf));
                    chk($sformatf("stall%0d tag stable", k), 32'(to0), 32'(st));
                    chk($sformatf("stall%0d out_valid", k), ov0, 1);
                    chk($sformatf("stall%0d in_ready", k), in_ready0, 0);
                end
                sync();
                out_ready = 1'b1;
            end
        join
        drain("stall");

        sync();
        rnd_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(3) == 0) sync();
            send(8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
        end
        rnd_rdy = 1'b0;
        @(posedge g.clk);
        #2 out_ready = 1'b1;
        drain("random");

        lat_on = 1'b1;
        sync();
        send(8'h11, 8'h22, 1'b0, 4'd1);
        send(8'hF0, 8'h0F, 1'b1, 4'd2);
        send(8'h33, 8'h44, 1'b0, 4'd3);
        g.reset = 1'b1;
        sync();
        g.reset = 1'b0;
        @(negedge g.clk);
        chk("midreset out_valid", ov0, 0);
        chk("midreset f", f0, 0);
        chk("midreset tag_out", to0, 0);
        chk("midreset in_ready", in_ready0, 1);
        for (int k = 0; k < 12; k++) begin
            @(negedge g.clk);
            chk($sformatf("no stale beat %0d", k), ov0, 0);
        end
        chk("midreset q0 empty", q[0].size(), 0);
        chk("midreset q2 empty", q[2].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
